// File: rtl/img2col_pkg.sv
// img2col feeder shared types and geometry.
// Square ROW x ROW image, packed into even/odd column pairs.
package img2col_pkg;

  localparam int ROW         = 28;
  localparam int DATA_WIDTH  = 16;
  localparam int ADDRESS_NUM = 5;
  localparam int KERNEL      = 5;

  localparam logic [ADDRESS_NUM-1:0] IDLE_ADRS = '1;

  typedef enum logic [1:0] {
    IDLE,
    EVEN,
    ODD,
    DONE
  } feeder_state_t;

  typedef logic [DATA_WIDTH-1:0]  pixel_t;
  typedef logic [ADDRESS_NUM-1:0] adrs_t;

endpackage

// File: rtl/img2col_pos_counter.sv
// Column/row position of the current pair.
// col steps by 2 and wraps into row; last_o flags the final pair.
module img2col_pos_counter
  import img2col_pkg::*;
(
  input  logic  clk,
  input  logic  nrst,
  input  logic  clr_i,
  input  logic  adv_i,
  output adrs_t col_o,
  output adrs_t row_o,
  output logic  last_o
);

  localparam adrs_t COL_END = adrs_t'(ROW - 2);
  localparam adrs_t ROW_END = adrs_t'(ROW - 1);

  adrs_t col_q, col_d;
  adrs_t row_q, row_d;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clr_i) begin
      col_d = '0;
      row_d = '0;
    end else if (adv_i) begin
      if (col_q == COL_END) begin
        col_d = '0;
        // wrap row too so it never leaves 0..ROW-1
        row_d = (row_q == ROW_END) ? '0
              : row_q + adrs_t'(1);
      end else begin
        col_d = col_q + adrs_t'(2);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

  assign col_o  = col_q;
  assign row_o  = row_q;
  assign last_o = (col_q == COL_END) &&
                  (row_q == ROW_END);

endmodule

// File: rtl/img2col_feeder.sv
// Raster pixel stream to dual-lane PU writes.
// Pairs even/odd columns, flags full windows, frame end and s_last errors.
module img2col_feeder
  import img2col_pkg::*;
(
  input  logic   clk,
  input  logic   nrst,
  input  logic   s_valid,
  output logic   s_ready,
  input  pixel_t s_data,
  input  logic   s_last,
  input  logic   start,
  output pixel_t new1,
  output pixel_t new2,
  output adrs_t  adrs_in1,
  output adrs_t  adrs_in2,
  output logic   pair_valid,
  output adrs_t  row_idx,
  output logic   window_valid,
  output logic   frame_done,
  output logic   err_last
);

  feeder_state_t state_q, state_d;
  pixel_t hold_q, hold_d;
  pixel_t new1_q, new1_d;
  pixel_t new2_q, new2_d;
  adrs_t  a1_q, a1_d;
  adrs_t  a2_q, a2_d;
  adrs_t  row_q, row_d;
  logic   pv_q, pv_d;
  logic   err_q, err_d;

  logic  clr, adv, last_pix;
  adrs_t col, row;

  img2col_pos_counter u_pos (
    .clk    (clk),
    .nrst   (nrst),
    .clr_i  (clr),
    .adv_i  (adv),
    .col_o  (col),
    .row_o  (row),
    .last_o (last_pix)
  );

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    new1_d     = new1_q;
    new2_d     = new2_q;
    a1_d       = IDLE_ADRS;
    a2_d       = IDLE_ADRS;
    row_d      = row_q;
    pv_d       = 1'b0;
    err_d      = err_q;
    clr        = 1'b0;
    adv        = 1'b0;
    s_ready    = 1'b0;
    frame_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EVEN;
          clr     = 1'b1;
          err_d   = 1'b0;
        end
      end
      EVEN: begin
        s_ready = 1'b1;
        if (s_valid) begin
          hold_d  = s_data;
          state_d = ODD;
          // an even column is never the frame's last pixel
          if (s_last) err_d = 1'b1;
        end
      end
      ODD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          new1_d  = hold_q;
          new2_d  = s_data;
          a1_d    = col;
          a2_d    = col + adrs_t'(1);
          row_d   = row;
          pv_d    = 1'b1;
          adv     = 1'b1;
          if (s_last != last_pix) err_d = 1'b1;
          state_d = last_pix ? DONE : EVEN;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      new1_q  <= '0;
      new2_q  <= '0;
      a1_q    <= IDLE_ADRS;
      a2_q    <= IDLE_ADRS;
      row_q   <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      new1_q  <= new1_d;
      new2_q  <= new2_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      row_q   <= row_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
    end
  end

  assign new1       = new1_q;
  assign new2       = new2_q;
  assign adrs_in1   = a1_q;
  assign adrs_in2   = a2_q;
  assign pair_valid = pv_q;
  assign row_idx    = row_q;
  assign err_last   = err_q;

  assign window_valid = pv_q &
    (row_q >= adrs_t'(KERNEL - 1)) &
    (a2_q  >= adrs_t'(KERNEL - 1));

endmodule

// File: tb/tb_img2col_feeder.sv
// Scoreboard bench for img2col_feeder.
// Driver pushes expected pairs; a negedge monitor pops and compares.
module tb_img2col_feeder;
  import img2col_pkg::*;

  logic   clk = 1'b0;
  logic   nrst = 1'b0;
  logic   s_valid = 1'b0;
  logic   s_last = 1'b0;
  logic   start = 1'b0;
  pixel_t s_data = '0;
  logic   s_ready, pair_valid, window_valid;
  logic   frame_done, err_last;
  pixel_t new1, new2;
  adrs_t  adrs_in1, adrs_in2, row_idx;

  img2col_feeder dut (
    .clk          (clk),
    .nrst         (nrst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .start        (start),
    .new1         (new1),
    .new2         (new2),
    .adrs_in1     (adrs_in1),
    .adrs_in2     (adrs_in2),
    .pair_valid   (pair_valid),
    .row_idx      (row_idx),
    .window_valid (window_valid),
    .frame_done   (frame_done),
    .err_last     (err_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    pixel_t n1;
    pixel_t n2;
    adrs_t  a1;
    adrs_t  a2;
    adrs_t  r;
    logic   wv;
  } pair_t;

  localparam int NPIX  = ROW * ROW;
  localparam int NPAIR = NPIX / 2;

  pair_t  exp_q[$];
  pair_t  e;
  int     vecs = 0;
  int     errs = 0;
  int     cyc = 0;
  int     pairs = 0;
  int     dones = 0;
  int     first_cyc = -1;
  int     start_cyc = 0;
  bit     mon_en = 1'b0;
  pixel_t last1 = '0;
  pixel_t last2 = '0;
  logic   wv_cap [NPAIR];
  pair_t  fin;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d want %0d (t=%0t)",
               nm, act, req, $time);
    end
  endtask

  function automatic pair_t mk(int p);
    int c, r;
    c = (2 * p) % ROW;
    r = (2 * p) / ROW;
    mk.n1 = pixel_t'(2 * p);
    mk.n2 = pixel_t'(2 * p + 1);
    mk.a1 = adrs_t'(c);
    mk.a2 = adrs_t'(c + 1);
    mk.r  = adrs_t'(r);
    mk.wv = (r >= KERNEL - 1) && (c + 1 >= KERNEL - 1);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      if (pair_valid) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (pairs < NPAIR) wv_cap[pairs] = window_valid;
        fin = {new1, new2, adrs_in1, adrs_in2,
               row_idx, window_valid};
        pairs++;
        if (exp_q.size() == 0) begin
          chk("unexpected_pair", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("new1", new1, e.n1);
          chk("new2", new2, e.n2);
          chk("adrs_in1", adrs_in1, e.a1);
          chk("adrs_in2", adrs_in2, e.a2);
          chk("row_idx", row_idx, e.r);
          chk("window_valid", window_valid, e.wv);
        end
        last1 = new1;
        last2 = new2;
      end else begin
        chk("idle_adrs1", adrs_in1, 31);
        chk("idle_adrs2", adrs_in2, 31);
        chk("hold_new1", new1, last1);
        chk("hold_new2", new2, last2);
        chk("idle_wv", window_valid, 0);
      end
      if (frame_done) dones++;
    end
  end

  task automatic rst_chk();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_new1", new1, 0);
    chk("rst_new2", new2, 0);
    chk("rst_adrs1", adrs_in1, 31);
    chk("rst_adrs2", adrs_in2, 31);
    chk("rst_pv", pair_valid, 0);
    chk("rst_wv", window_valid, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_err", err_last, 0);
    chk("rst_row", row_idx, 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    start_cyc = cyc;
    first_cyc = -1;
    pairs = 0;
    dones = 0;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(int i, bit lst, int gap);
    bit ok = 1'b0;
    s_valid = 1'b1;
    s_data  = pixel_t'(i);
    s_last  = lst;
    if (i % 2 == 1) exp_q.push_back(mk(i / 2));
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      if (s_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    if (!ok) chk("accept_timeout", 0, 1);
    if (gap > 0) begin
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_data  = 16'hBEEF;
      repeat (gap) @(posedge clk);
      #1;
    end
  endtask

  task automatic run(int gapm, int n, int bad, int poke);
    int g;
    for (int i = 0; i < n; i++) begin
      if (i == poke) begin
        s_valid = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        chk("poke_ready", s_ready, 1);
        chk("poke_new1", new1, 48);
        chk("poke_new2", new2, 49);
        chk("poke_row", row_idx, 1);
        chk("poke_pv", pair_valid, 0);
      end
      g = (gapm == 0) ? 0 : ((i == 100) ? 5 : 1);
      if (i == bad) chk("err_before", err_last, 0);
      send(i, (i == bad) || (i == NPIX - 1), g);
      if (i == bad) chk("err_after", err_last, 1);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_done(string nm);
    for (int t = 0; t < 10 && dones == 0; t++)
      @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk({nm, "_pairs"}, pairs, NPAIR);
    chk({nm, "_frame_done"}, dones, 1);
    chk({nm, "_sb_empty"}, exp_q.size(), 0);
    chk({nm, "_idle_ready"}, s_ready, 0);
  endtask

  task automatic final_chk(string nm);
    chk({nm, "_fin_new1"}, fin.n1, 782);
    chk({nm, "_fin_new2"}, fin.n2, 783);
    chk({nm, "_fin_a1"}, fin.a1, 26);
    chk({nm, "_fin_a2"}, fin.a2, 27);
    chk({nm, "_fin_row"}, fin.r, 27);
  endtask

  initial begin
    int fw;
    repeat (3) @(posedge clk);
    #1;
    rst_chk();
    nrst = 1'b1;
    mon_en = 1'b1;

    pulse_start();
    run(0, NPIX, -1, -1);
    wait_done("A");
    chk("first_pair_cycle", first_cyc - start_cyc, 3);
    chk("A_err", err_last, 0);
    final_chk("A");
    fw = -1;
    for (int k = NPAIR - 1; k >= 0; k--)
      if (wv_cap[k] === 1'b1) fw = k;
    chk("wv_first_pair", fw, 58);
    chk("wv_r4_c2", wv_cap[57], 0);
    chk("wv_r4_c4", wv_cap[58], 1);
    chk("wv_r10_c2", wv_cap[141], 0);
    chk("wv_r27_c26", wv_cap[391], 1);

    pulse_start();
    run(1, NPIX, -1, -1);
    wait_done("B");
    chk("B_err", err_last, 0);
    final_chk("B");

    pulse_start();
    run(0, NPIX, 100, -1);
    wait_done("C");
    chk("C_err_sticky", err_last, 1);
    final_chk("C");

    pulse_start();
    chk("start_clears_err", err_last, 0);
    run(0, 51, -1, -1);
    mon_en = 1'b0;
    nrst = 1'b0;
    @(posedge clk); #1;
    rst_chk();
    chk("rst_sb_empty", exp_q.size(), 0);
    nrst = 1'b1;
    last1 = '0;
    last2 = '0;
    mon_en = 1'b1;

    pulse_start();
    run(0, NPIX, -1, 51);
    wait_done("E");
    chk("E_err", err_last, 0);
    final_chk("E");

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, errs);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
